// File: rtl/mac_tx_if.sv
// Byte-stream bundle for the MAC transmitter: input stream (s_*), output
// stream (m_*) and per-frame completion status.
interface mac_tx_if;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic        tx_done;
    logic        tx_oversize;
    logic [15:0] tx_len_total;

    // Transmitter side: consumes s_*, produces m_* and status
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last,
        output tx_done, tx_oversize, tx_len_total
    );

    // Environment side: produces s_*, consumes m_* and status
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last,
        input  tx_done, tx_oversize, tx_len_total
    );
endinterface

// File: rtl/mac_tx.sv
// MAC transmitter: passes header/payload bytes through a single output
// register, zero-pads frames shorter than 60 bytes and appends the
// Ethernet CRC-32 FCS least-significant byte first.
module mac_tx (
    input  logic      clk,
    input  logic      rst_n,
    mac_tx_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;

    function automatic logic [31:0] crc32_eth_init();
        return '1;
    endfunction

    function automatic logic [31:0] crc32_eth_update(input logic [31:0] crc,
                                                     input logic [7:0]  d);
        logic [31:0] c;
        c = crc ^ {24'h000000, d};
        for (int unsigned k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] crc32_eth_final(input logic [31:0] crc);
        return ~crc;
    endfunction

    state_t      r_state, w_state_nxt;
    logic [31:0] r_crc, w_crc_nxt, w_crc_upd;
    logic [15:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [1:0]  r_idx, w_idx_nxt;
    logic [31:0] r_fcs, w_fcs_nxt;
    logic [15:0] r_frame, w_frame_nxt;
    logic        r_mvalid, w_mvalid_nxt;
    logic [7:0]  r_mdata, w_mdata_nxt;
    logic        r_mlast, w_mlast_nxt;
    logic        r_done, r_oversize;
    logic [15:0] r_len_total;
    logic        w_load, w_hs_last;

    assign w_load    = !r_mvalid || bus.m_ready;
    assign w_hs_last = r_mvalid && bus.m_ready && r_mlast;
    assign w_cnt_inc = r_cnt + 16'd1;

    assign bus.s_ready      = w_load && ((r_state == IDLE) || (r_state == DATA));
    assign bus.m_valid      = r_mvalid;
    assign bus.m_data       = r_mdata;
    assign bus.m_last       = r_mlast;
    assign bus.tx_done      = r_done;
    assign bus.tx_oversize  = r_oversize;
    assign bus.tx_len_total = r_len_total;

    // Next-state and output-register contents; nothing moves unless the
    // output register can be loaded
    always_comb begin
        w_state_nxt  = r_state;
        w_crc_nxt    = r_crc;
        w_crc_upd    = '0;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_fcs_nxt    = r_fcs;
        w_frame_nxt  = r_frame;
        w_mvalid_nxt = r_mvalid;
        w_mdata_nxt  = r_mdata;
        w_mlast_nxt  = r_mlast;
        if (w_load) begin
            case (r_state)
                IDLE, DATA: begin
                    if (bus.s_valid) begin
                        w_crc_upd    = crc32_eth_update(r_crc, bus.s_data);
                        w_mvalid_nxt = 1'b1;
                        w_mdata_nxt  = bus.s_data;
                        w_mlast_nxt  = 1'b0;
                        w_crc_nxt    = w_crc_upd;
                        w_cnt_nxt    = w_cnt_inc;
                        if (!bus.s_last) begin
                            w_state_nxt = DATA;
                        end else if (w_cnt_inc < 16'd60) begin
                            w_state_nxt = PAD;
                        end else begin
                            w_state_nxt = FCS;
                            w_fcs_nxt   = crc32_eth_final(w_crc_upd);
                            w_frame_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_mvalid_nxt = 1'b0;
                        w_mlast_nxt  = 1'b0;
                    end
                end
                PAD: begin
                    w_crc_upd    = crc32_eth_update(r_crc, 8'h00);
                    w_mvalid_nxt = 1'b1;
                    w_mdata_nxt  = 8'h00;
                    w_mlast_nxt  = 1'b0;
                    w_crc_nxt    = w_crc_upd;
                    w_cnt_nxt    = w_cnt_inc;
                    if (w_cnt_inc == 16'd60) begin
                        w_state_nxt = FCS;
                        w_fcs_nxt   = crc32_eth_final(w_crc_upd);
                        w_frame_nxt = w_cnt_inc;
                    end
                end
                FCS: begin
                    w_mvalid_nxt = 1'b1;
                    case (r_idx)
                        2'd0:    w_mdata_nxt = r_fcs[7:0];
                        2'd1:    w_mdata_nxt = r_fcs[15:8];
                        2'd2:    w_mdata_nxt = r_fcs[23:16];
                        default: w_mdata_nxt = r_fcs[31:24];
                    endcase
                    w_mlast_nxt = (r_idx == 2'd3);
                    if (r_idx == 2'd3) begin
                        w_state_nxt = IDLE;
                        w_crc_nxt   = crc32_eth_init();
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 2'd1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, CRC, counters and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_crc    <= crc32_eth_init();
            r_cnt    <= '0;
            r_idx    <= '0;
            r_fcs    <= '0;
            r_frame  <= '0;
            r_mvalid <= 1'b0;
            r_mdata  <= '0;
            r_mlast  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_crc    <= w_crc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_fcs    <= w_fcs_nxt;
            r_frame  <= w_frame_nxt;
            r_mvalid <= w_mvalid_nxt;
            r_mdata  <= w_mdata_nxt;
            r_mlast  <= w_mlast_nxt;
        end
    end

    // Completion status, reported the cycle after the final FCS handshake;
    // r_frame was captured at FCS entry so the next frame may already count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done      <= 1'b0;
            r_oversize  <= 1'b0;
            r_len_total <= '0;
        end else if (w_hs_last) begin
            r_done      <= 1'b1;
            r_oversize  <= (r_frame > 16'd1514);
            r_len_total <= r_frame + 16'd4;
        end else begin
            r_done      <= 1'b0;
            r_oversize  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_tx.sv
// Self-checking bench for mac_tx: frame-level model (pad + CRC-32 FCS)
// feeding an expected-byte queue, checked against every output handshake.
module tb_mac_tx;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mac_tx_if bus();

    mac_tx u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    bit         expl_q[$];
    int         len_q[$];
    bit         ov_q[$];
    logic [7:0] rx_q[$];
    bit rand_ready = 1'b0;
    int done_cnt = 0;
    int ov_cnt = 0;
    int sent_ok = 0;
    bit gap_watch = 1'b0;
    bit gap_started = 1'b0;
    int gaps = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference CRC-32, bit-serial over the whole byte sequence
    function automatic logic [31:0] crc_ref(input bq_t d);
        logic [31:0] c;
        logic fb;
        c = '1;
        foreach (d[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[i][b];
                c = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    // Wire image of a frame: data, zero pad to 60, FCS LSB first
    function automatic bq_t model_bytes(input bq_t d);
        bq_t p;
        logic [31:0] f;
        p = d;
        while (p.size() < 60) p.push_back(8'h00);
        f = crc_ref(p);
        for (int k = 0; k < 4; k++) p.push_back(f[8*k +: 8]);
        return p;
    endfunction

    task automatic model_push(input bq_t d);
        bq_t w;
        w = model_bytes(d);
        foreach (w[i]) begin
            exp_q.push_back(w[i]);
            expl_q.push_back(i == w.size() - 1);
        end
        len_q.push_back(w.size());
        ov_q.push_back((w.size() - 4) > 1514);
    endtask

    function automatic bq_t make_frame(input int len, input int seed);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(8'((i * 37 + seed * 13 + 5) & 255));
        return q;
    endfunction

    function automatic bq_t rand_frame(input int len);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    // Drive one frame; abort_at > 0 asserts reset after that many accepts
    task automatic send_frame(input bq_t d, input int abort_at, input bit rand_valid);
        int i;
        int waitc;
        bit acc;
        i = 0;
        waitc = 0;
        model_push(d);
        while (i < d.size()) begin
            bus.s_data  = d[i];
            bus.s_last  = (i == d.size() - 1);
            bus.s_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            acc = bus.s_valid && bus.s_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                i++;
                waitc = 0;
                if (i == abort_at) begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check("rst_m_valid", bus.m_valid, 0);
                    check("rst_m_last", bus.m_last, 0);
                    check("rst_m_data", bus.m_data, 0);
                    check("rst_tx_len_total", bus.tx_len_total, 0);
                    exp_q.delete();
                    expl_q.delete();
                    len_q.delete();
                    ov_q.delete();
                    bus.s_valid = 1'b0;
                    bus.s_last  = 1'b0;
                    repeat (2) @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    return;
                end
            end else begin
                waitc++;
                if (waitc > 2000) begin
                    tests++;
                    fails++;
                    $display("FAIL input_accept_timeout: byte %0d of %0d not accepted", i, d.size());
                    bus.s_valid = 1'b0;
                    return;
                end
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        sent_ok++;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && n < 40000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_remaining", exp_q.size() + len_q.size(), 0);
    endtask

    // Downstream ready: always 1, or a coin toss per cycle
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output compare against the model, sampled mid-cycle
    initial begin
        logic [7:0] pd;
        logic [7:0] e;
        bit pl;
        bit el;
        bit stalled;
        stalled = 1'b0;
        pd = '0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
                rx_q.delete();
                continue;
            end
            if (stalled) begin
                check("stall_m_valid", bus.m_valid, 1);
                check("stall_m_data", bus.m_data, pd);
                check("stall_m_last", bus.m_last, pl);
            end
            if (gap_watch) begin
                if (bus.m_valid) gap_started = 1'b1;
                else if (gap_started && exp_q.size() > 0) gaps++;
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_byte: got 0x%0h, expected no output", bus.m_data);
                end else begin
                    e  = exp_q.pop_front();
                    el = expl_q.pop_front();
                    check("m_data", bus.m_data, e);
                    check("m_last", bus.m_last, el);
                end
                rx_q.push_back(bus.m_data);
                if (bus.m_last) begin
                    check("rx_fcs_residue", crc_ref(rx_q), 32'h2144DF1C);
                    rx_q.delete();
                end
            end
            stalled = bus.m_valid && !bus.m_ready;
            pd = bus.m_data;
            pl = bus.m_last;
            if (bus.tx_done) begin
                done_cnt++;
                if (bus.tx_oversize) ov_cnt++;
                if (len_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_tx_done: got tx_done=1, expected 0");
                end else begin
                    check("tx_len_total", bus.tx_len_total, len_q.pop_front());
                    check("tx_oversize", bus.tx_oversize, ov_q.pop_front());
                end
            end else if (bus.tx_oversize) begin
                tests++;
                fails++;
                $display("FAIL oversize_without_done: got tx_oversize=1, expected 0");
            end
        end
    end

    initial begin
        #1200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1);
    end

    initial begin
        bq_t q;
        bq_t w;
        int len;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;

        // Reset values
        #23;
        check("reset_m_valid", bus.m_valid, 0);
        check("reset_m_data", bus.m_data, 0);
        check("reset_m_last", bus.m_last, 0);
        check("reset_tx_done", bus.tx_done, 0);
        check("reset_tx_oversize", bus.tx_oversize, 0);
        check("reset_tx_len_total", bus.tx_len_total, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("s_ready_after_reset", bus.s_ready, 1);

        // Pin the model with known CRC-32 values and frame shape
        q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("model_crc_123456789", crc_ref(q), 32'hCBF43926);
        q = '{8'h61};
        check("model_crc_a", crc_ref(q), 32'hE8B7BE43);
        q = '{8'hAA};
        w = model_bytes(q);
        check("model_1byte_len", w.size(), 64);
        check("model_1byte_b0", w[0], 8'hAA);
        check("model_1byte_b59", w[59], 8'h00);
        w = model_bytes(make_frame(1514, 2));
        check("model_1514_len", w.size(), 1518);

        @(posedge clk);
        #1;

        // 60-byte frame (14 header + 46 payload)
        send_frame(make_frame(60, 1), 0, 1'b0);
        wait_drain();
        check("len_60", bus.tx_len_total, 64);

        // 20-byte frame, padded
        send_frame(make_frame(20, 3), 0, 1'b0);
        wait_drain();
        check("len_20", bus.tx_len_total, 64);

        // 1-byte frame 0xAA
        q = '{8'hAA};
        send_frame(q, 0, 1'b0);
        wait_drain();
        check("len_1", bus.tx_len_total, 64);

        // Back-to-back 60 then 1514 with no output gaps
        gaps = 0;
        gap_started = 1'b0;
        gap_watch = 1'b1;
        ov_cnt = 0;
        send_frame(make_frame(60, 4), 0, 1'b0);
        send_frame(make_frame(1514, 5), 0, 1'b0);
        wait_drain();
        gap_watch = 1'b0;
        check("b2b_gaps", gaps, 0);
        check("len_1514", bus.tx_len_total, 1518);
        check("b2b_oversize_count", ov_cnt, 0);

        // Oversize frame still sent in full
        send_frame(make_frame(1515, 6), 0, 1'b0);
        wait_drain();
        check("len_1515", bus.tx_len_total, 1519);
        check("oversize_count", ov_cnt, 1);

        // Reset at byte 30 of a 100-byte frame, then a clean 64-byte frame
        send_frame(make_frame(100, 7), 30, 1'b0);
        @(posedge clk);
        #1;
        send_frame(make_frame(64, 8), 0, 1'b0);
        wait_drain();
        check("len_after_reset", bus.tx_len_total, 68);

        // Random valid/ready over 200 frames
        rand_ready = 1'b1;
        for (int f = 0; f < 200; f++) begin
            if (f % 67 == 33) len = $urandom_range(1400, 1514);
            else len = $urandom_range(1, 80);
            send_frame(rand_frame(len), 0, 1'b1);
        end
        wait_drain();
        rand_ready = 1'b0;

        check("frames_done", done_cnt, sent_ok);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
